// File: rtl/p_out_patdet.sv
// P output stage: result/carry registers, PCOUT cascade, masked pattern detect, overflow/underflow.
// Optional macro AUTORESET_PATDET_EN: clear P/carry on the edge after a registered pattern match.
module p_out_patdet #(
  parameter int unsigned PREG               = 1,
  parameter int unsigned USE_PATTERN_DETECT = 1,
  parameter logic [47:0] PATTERN            = 48'h0,
  parameter logic [47:0] MASK               = 48'h3FFF_FFFF_FFFF,
  parameter int unsigned SEL_PATTERN        = 0,
  parameter int unsigned SEL_MASK           = 0
) (
  input  logic        CLK,
  input  logic        RSTP,
  input  logic        CEP,
  input  logic [47:0] ALU_OUT,
  input  logic [3:0]  ALU_CARRYOUT,
  input  logic [47:0] C,
  output logic [47:0] P,
  output logic [47:0] PCOUT,
  output logic [3:0]  CARRYOUT,
  output logic        CARRYCASCOUT,
  output logic        PATTERNDETECT,
  output logic        PATTERNBDETECT,
  output logic        OVERFLOW,
  output logic        UNDERFLOW
);

  localparam int unsigned W  = 48;
  localparam int unsigned CW = 4;

`ifdef AUTORESET_PATDET_EN
  localparam bit AUTORESET = (PREG != 0);
`else
  localparam bit AUTORESET = 1'b0;
`endif

  logic [W-1:0]  pat, msk;
  logic          pd_c, pbd_c;
  logic [W-1:0]  p_d, p_q;
  logic [CW-1:0] carry_d, carry_q;
  logic          pd_q, pbd_q, pd_past_q, pbd_past_q;

  // Masked compare against the selected pattern and its complement
  always_comb begin
    pat   = (SEL_PATTERN != 0) ? C : PATTERN;
    msk   = (SEL_MASK != 0) ? C : MASK;
    pd_c  = (USE_PATTERN_DETECT != 0) && (&(~(ALU_OUT ^ pat) | msk));
    pbd_c = (USE_PATTERN_DETECT != 0) && (&(~(ALU_OUT ^ ~pat) | msk));
  end

  // A registered match terminates the count when auto-reset is built in
  always_comb begin
    p_d     = ALU_OUT;
    carry_d = ALU_CARRYOUT;
    if (AUTORESET && pd_q) begin
      p_d     = '0;
      carry_d = '0;
    end
  end

  always_ff @(posedge CLK or posedge RSTP) begin
    if (RSTP) begin
      p_q        <= '0;
      carry_q    <= '0;
      pd_q       <= 1'b0;
      pbd_q      <= 1'b0;
      pd_past_q  <= 1'b0;
      pbd_past_q <= 1'b0;
    end else if (CEP) begin
      p_q        <= p_d;
      carry_q    <= carry_d;
      pd_q       <= pd_c;
      pbd_q      <= pbd_c;
      pd_past_q  <= pd_q;
      pbd_past_q <= pbd_q;
    end
  end

  // Flags need the previous cycle's detect, so they only exist on the registered path
  always_comb begin
    if (PREG != 0) begin
      P              = p_q;
      CARRYOUT       = carry_q;
      PATTERNDETECT  = pd_q;
      PATTERNBDETECT = pbd_q;
      OVERFLOW       = pd_past_q & ~pd_q & ~pbd_q;
      UNDERFLOW      = pbd_past_q & ~pd_q & ~pbd_q;
    end else begin
      P              = ALU_OUT;
      CARRYOUT       = ALU_CARRYOUT;
      PATTERNDETECT  = pd_c;
      PATTERNBDETECT = pbd_c;
      OVERFLOW       = 1'b0;
      UNDERFLOW      = 1'b0;
    end
    PCOUT        = P;
    CARRYCASCOUT = CARRYOUT[CW-1];
  end

endmodule

// File: tb/tb_p_out_patdet.sv
// Directed bench for p_out_patdet: reset, latency/enable, overflow/underflow, dynamic pattern, counter.
module tb_p_out_patdet;

  logic        clk = 1'b0;
  logic        rstp;
  logic        cep, cep_cnt;
  logic [47:0] alu, c;
  logic [3:0]  carry;
  int          n_chk = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  // Registered, default pattern/mask
  logic [47:0] p_r, pc_r;
  logic [3:0]  co_r;
  logic        cc_r, pd_r, pbd_r, ov_r, uf_r;
  p_out_patdet u_dut (.CLK(clk), .RSTP(rstp), .CEP(cep), .ALU_OUT(alu), .ALU_CARRYOUT(carry), .C(c),
    .P(p_r), .PCOUT(pc_r), .CARRYOUT(co_r), .CARRYCASCOUT(cc_r), .PATTERNDETECT(pd_r),
    .PATTERNBDETECT(pbd_r), .OVERFLOW(ov_r), .UNDERFLOW(uf_r));

  // Combinational path
  logic [47:0] p_b, pc_b;
  logic [3:0]  co_b;
  logic        cc_b, pd_b, pbd_b, ov_b, uf_b;
  p_out_patdet #(.PREG(0)) u_comb (.CLK(clk), .RSTP(rstp), .CEP(cep), .ALU_OUT(alu), .ALU_CARRYOUT(carry), .C(c),
    .P(p_b), .PCOUT(pc_b), .CARRYOUT(co_b), .CARRYCASCOUT(cc_b), .PATTERNDETECT(pd_b),
    .PATTERNBDETECT(pbd_b), .OVERFLOW(ov_b), .UNDERFLOW(uf_b));

  // C as pattern, nothing masked
  logic [47:0] p_y, pc_y;
  logic [3:0]  co_y;
  logic        cc_y, pd_y, pbd_y, ov_y, uf_y;
  p_out_patdet #(.SEL_PATTERN(1), .MASK(48'h0)) u_dyn (.CLK(clk), .RSTP(rstp), .CEP(cep), .ALU_OUT(alu),
    .ALU_CARRYOUT(carry), .C(c), .P(p_y), .PCOUT(pc_y), .CARRYOUT(co_y), .CARRYCASCOUT(cc_y),
    .PATTERNDETECT(pd_y), .PATTERNBDETECT(pbd_y), .OVERFLOW(ov_y), .UNDERFLOW(uf_y));

  // Everything masked
  logic [47:0] p_m, pc_m;
  logic [3:0]  co_m;
  logic        cc_m, pd_m, pbd_m, ov_m, uf_m;
  p_out_patdet #(.MASK(48'hFFFF_FFFF_FFFF)) u_msk (.CLK(clk), .RSTP(rstp), .CEP(cep), .ALU_OUT(alu),
    .ALU_CARRYOUT(carry), .C(c), .P(p_m), .PCOUT(pc_m), .CARRYOUT(co_m), .CARRYCASCOUT(cc_m),
    .PATTERNDETECT(pd_m), .PATTERNBDETECT(pbd_m), .OVERFLOW(ov_m), .UNDERFLOW(uf_m));

  // Detect disabled
  logic [47:0] p_n, pc_n;
  logic [3:0]  co_n;
  logic        cc_n, pd_n, pbd_n, ov_n, uf_n;
  p_out_patdet #(.USE_PATTERN_DETECT(0)) u_npd (.CLK(clk), .RSTP(rstp), .CEP(cep), .ALU_OUT(alu),
    .ALU_CARRYOUT(carry), .C(c), .P(p_n), .PCOUT(pc_n), .CARRYOUT(co_n), .CARRYCASCOUT(cc_n),
    .PATTERNDETECT(pd_n), .PATTERNBDETECT(pbd_n), .OVERFLOW(ov_n), .UNDERFLOW(uf_n));

  // P+1 feedback counter terminated by pattern 10
  logic [47:0] p_k, pc_k, alu_k;
  logic [3:0]  co_k;
  logic        cc_k, pd_k, pbd_k, ov_k, uf_k;
  assign alu_k = p_k + 48'd1;
  p_out_patdet #(.PATTERN(48'd10), .MASK(48'h0)) u_cnt (.CLK(clk), .RSTP(rstp), .CEP(cep_cnt), .ALU_OUT(alu_k),
    .ALU_CARRYOUT(carry), .C(c), .P(p_k), .PCOUT(pc_k), .CARRYOUT(co_k), .CARRYCASCOUT(cc_k),
    .PATTERNDETECT(pd_k), .PATTERNBDETECT(pbd_k), .OVERFLOW(ov_k), .UNDERFLOW(uf_k));

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rstp = 1'b1; cep = 1'b0; cep_cnt = 1'b0;
    alu = '0; c = '0; carry = '0;
    #12;
    chk("rst_p", p_r, 48'h0);
    chk("rst_pcout", pc_r, 48'h0);
    chk("rst_co", 48'(co_r), 48'h0);
    chk("rst_pd", 48'(pd_r), 48'h0);
    chk("rst_ov", 48'(ov_r), 48'h0);
    rstp = 1'b0;

    // Asynchronous reset between edges
    alu = 48'h1234; cep = 1'b1;
    tick();
    chk("load_1234", p_r, 48'h1234);
    chk("pd_1234", 48'(pd_r), 48'h1);
    #2 rstp = 1'b1;
    #1;
    chk("async_rst_p", p_r, 48'h0);
    chk("async_rst_pcout", pc_r, 48'h0);
    chk("async_rst_pd", 48'(pd_r), 48'h0);
    chk("comb_p_in_rst", p_b, 48'h1234);
    rstp = 1'b0;

    // Latency and enable
    alu = 48'd5; carry = 4'h8;
    #1;
    chk("pre_edge_p", p_r, 48'h0);
    chk("comb_p", p_b, 48'd5);
    chk("comb_casc", 48'(cc_b), 48'h1);
    tick();
    chk("lat_p5", p_r, 48'd5);
    chk("lat_casc", 48'(cc_r), 48'h1);
    alu = 48'd9; carry = 4'h0; cep = 1'b0;
    tick(3);
    chk("hold_p5", p_r, 48'd5);
    chk("hold_pcout", pc_r, 48'd5);
    chk("hold_casc", 48'(cc_r), 48'h1);
    cep = 1'b1;
    tick();
    chk("resume_p9", p_r, 48'd9);
    chk("resume_casc", 48'(cc_r), 48'h0);

    // Overflow
    alu = 48'h0000_0000_0FFF;
    tick();
    chk("ov_pd", 48'(pd_r), 48'h1);
    chk("ov_first", 48'(ov_r), 48'h0);
    alu = 48'h4000_0000_0000;
    #1;
    chk("comb_pd_4000", 48'(pd_b), 48'h0);
    chk("comb_ov_tied", 48'(ov_b), 48'h0);
    tick();
    chk("ov_flag", 48'(ov_r), 48'h1);
    chk("ov_uf", 48'(uf_r), 48'h0);

    // Underflow
    alu = 48'hFFFF_FFFF_FFFF;
    tick();
    chk("uf_pbd", 48'(pbd_r), 48'h1);
    chk("uf_first", 48'(uf_r), 48'h0);
    alu = 48'hBFFF_FFFF_FFFF;
    tick();
    chk("uf_flag", 48'(uf_r), 48'h1);
    chk("uf_ov", 48'(ov_r), 48'h0);
    chk("npd_pbd", 48'(pbd_n), 48'h0);

    // Full mask: both detects high, no flags
    chk("msk_pd", 48'(pd_m), 48'h1);
    chk("msk_pbd", 48'(pbd_m), 48'h1);
    chk("msk_ov", 48'(ov_m), 48'h0);
    chk("msk_uf", 48'(uf_m), 48'h0);

    // Dynamic pattern from C
    c = 48'hABCD; alu = 48'hABCD;
    tick();
    chk("dyn_match", 48'(pd_y), 48'h1);
    alu = 48'hABCC;
    tick();
    chk("dyn_miss", 48'(pd_y), 48'h0);
    c = 48'h1111; alu = 48'h1111;
    tick();
    chk("dyn_same_cycle_c", 48'(pd_y), 48'h1);

    // Reset mid-operation clears past detect
    alu = 48'h0;
    tick(2);
    chk("npd_pd", 48'(pd_n), 48'h0);
    chk("pre_rst_pd", 48'(pd_r), 48'h1);
    #2 rstp = 1'b1;
    #2 rstp = 1'b0;
    alu = 48'h4000_0000_0000;
    tick();
    chk("post_rst_ov", 48'(ov_r), 48'h0);

    // Match-terminated counter
    cep = 1'b0; cep_cnt = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("cnt", p_k, 48'(i));
    end
    tick();
`ifdef AUTORESET_PATDET_EN
    chk("cnt_autoreset", p_k, 48'd0);
    tick();
    chk("cnt_restart", p_k, 48'd1);
`else
    chk("cnt_no_autoreset", p_k, 48'd11);
    tick();
    chk("cnt_continue", p_k, 48'd12);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/p_out_patdet.md
Name: p_out_patdet

Overview:
Output end of the DSP slice datapath. It captures the 48-bit ALU result into the P register, drives the P and PCOUT cascade, and registers carry-out. It compares the result against a masked pattern and derives overflow/underflow from current and previous-cycle detect. It is the counterpart of the A/D pre-adder input stage: that block feeds operands in, this one takes results out.

Parameters:
PREG, 1, 0 = P path combinational (bypass), 1 = P path registered
USE_PATTERN_DETECT, 1, 0 = all detect/overflow/underflow outputs tied 0
PATTERN, 48'h0, static compare pattern
MASK, 48'h3FFF_FFFF_FFFF, static mask; 1 = bit ignored in compare
SEL_PATTERN, 0, 0 = use PATTERN, 1 = use C port as pattern
SEL_MASK, 0, 0 = use MASK, 1 = use C port as mask

Ports:
CLK  in  1  clock
RSTP  in  1  asynchronous active-high reset of all P-stage registers
CEP  in  1  clock enable for all P-stage registers
ALU_OUT  in  48  ALU result (signed)
ALU_CARRYOUT  in  4  ALU per-segment carry-outs
C  in  48  C operand, used as dynamic pattern/mask
P  out  48  result
PCOUT  out  48  cascade output, always equal to P
CARRYOUT  out  4  carry-out, registered per PREG
CARRYCASCOUT  out  1  equals CARRYOUT[3]
PATTERNDETECT  out  1  masked match against pattern
PATTERNBDETECT  out  1  masked match against ~pattern
OVERFLOW  out  1  overflow flag
UNDERFLOW  out  1  underflow flag

Behaviour:
- Reset: RSTP=1 clears P_REG, CARRY_REG, PD_REG, PBD_REG, PD_PAST and PBD_PAST to 0 immediately and independent of CLK or CEP. All outputs are 0 while reset is held and PREG=1.
- Register update: on posedge CLK with CEP=1 and RSTP=0, P_REG<=ALU_OUT and CARRY_REG<=ALU_CARRYOUT. When CEP=0 all registers hold.
- PREG=1: P, CARRYOUT, PATTERNDETECT and PATTERNBDETECT are taken from registers. Latency is 1 enabled cycle.
- PREG=0: these outputs are combinational from the inputs, with zero latency.
- Pattern select: pat = SEL_PATTERN ? C : PATTERN. Mask select: msk = SEL_MASK ? C : MASK.
- Pattern detect: pd_c = &(~(ALU_OUT ^ pat) | msk). PD_REG<=pd_c.
- Pattern-bar detect: pbd_c = &(~(ALU_OUT ^ ~pat) | msk). PBD_REG<=pbd_c.
- If pat and msk both select C and C changes, the compare uses the C value present in the same cycle as ALU_OUT.
- Past-detect registers: on each enabled edge PD_PAST<=PD_REG and PBD_PAST<=PBD_REG. These hold the previous enabled cycle's detect values.
- Overflow: OVERFLOW = PD_PAST & ~PATTERNDETECT & ~PATTERNBDETECT.
- Underflow: UNDERFLOW = PBD_PAST & ~PATTERNDETECT & ~PATTERNBDETECT.
- Both flags are valid only when PREG=1. With PREG=0 they are tied 0.
- USE_PATTERN_DETECT=0: PATTERNDETECT, PATTERNBDETECT, OVERFLOW and UNDERFLOW are constant 0, and the detect registers may be optimized away.
- Boundary: with msk all ones, PATTERNDETECT and PATTERNBDETECT are both 1. In that case OVERFLOW and UNDERFLOW are 0.
- Reset mid-operation: the past registers are cleared, so the first enabled cycle after reset release cannot flag OVERFLOW or UNDERFLOW.

Optional Feature:
AUTORESET_PATDET_EN
- Defined: when PATTERNDETECT=1 (registered) and CEP=1, the next enabled edge loads P_REG and CARRY_REG with 0 instead of ALU_OUT. PD_REG and PBD_REG update normally from ALU_OUT. This implements a match-terminated counter. Requires PREG=1; with PREG=0 the feature has no effect.
- Not defined: no auto-reset; P always follows ALU_OUT.

Test Plan:
- Reset: drive ALU_OUT=48'h1234 with CEP=1, clock, then assert RSTP between edges -> P=0, PCOUT=0 and all flags 0 immediately, before the next edge.
- Latency and enable, PREG=1: ALU_OUT=5, CEP=1 -> P=5 after one edge. Then ALU_OUT=9, CEP=0 for 3 edges -> P stays 5. Then CEP=1 -> P=9. CARRYCASCOUT tracks ALU_CARRYOUT[3] with the same latency.
- Overflow, default PATTERN/MASK: ALU_OUT sequence 48'h0000_0000_0FFF then 48'h4000_0000_0000 -> PATTERNDETECT=1 on the first cycle, then OVERFLOW=1 on the second cycle. UNDERFLOW stays 0.
- Underflow, default PATTERN/MASK: ALU_OUT=48'hFFFF_FFFF_FFFF (PATTERNBDETECT=1) then 48'hBFFF_FFFF_FFFF -> UNDERFLOW=1 on the second cycle. OVERFLOW stays 0.
- Dynamic pattern: SEL_PATTERN=1, MASK=0, C=48'hABCD, ALU_OUT=48'hABCD -> PATTERNDETECT=1. Change ALU_OUT to 48'hABCC -> PATTERNDETECT=0.
- AUTORESET_PATDET_EN defined, SEL_PATTERN=0, PATTERN=10, MASK=0, ALU_OUT=P+1 feedback from 0 -> P counts 1..10, the cycle after P=10 shows P=0, then counting resumes at 1.
